// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU clock-enable controller: FSM state encodings
// and default debounce / slow-step constants used by the board top and bench.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RUN       = 2'b00,
      S_STEP_IDLE = 2'b01,
      S_STEP_FIRE = 2'b10,
      S_AUTO      = 2'b11
   } state_t;

   // Debounce window in clk cycles and auto-step period exponent.
   localparam int DEB_CNT_DEFAULT = 1000000;
   localparam int SLOW_W_DEFAULT  = 25;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button into clk, debounces it and produces a
// one-cycle press pulse on the cycle after the debounced level rises.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-low reset
//   btn    in   raw asynchronous button, active-high
//   btn_db out  debounced button level
//   press  out  registered one-cycle pulse after btn_db goes 0->1
// -----------------------------------------------------------------------------
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic btn_db,
   output logic press
);

   localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          db_prev_q, db_prev_d;
   logic          press_q, press_d;

   always_comb begin
      sync_d    = {sync_q[0], btn};
      cnt_d     = '0;
      db_d      = db_q;
      db_prev_d = db_q;
      // Any cycle where the synchronised level matches btn_db restarts the
      // window, so a toggle needs DEB_CNT consecutive mismatched cycles.
      if (sync_q[1] != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = db_q & ~db_prev_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         press_q   <= press_d;
      end
   end

   assign btn_db = db_q;
   assign press  = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// CPU clock-enable controller. Produces a registered single-cycle-wide cpu_en
// for free-run, manual single-step and slow auto-step modes, and counts the
// cycles in which cpu_en was asserted.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   step_mode in   1 = step/auto modes, 0 = free run
//   auto      in   in step_mode: 1 = slow auto-step, 0 = manual button
//   btn       in   raw step push-button
//   halt      in   suppresses enables while high
//   clr_cnt   in   synchronous clear of step_cnt (wins over increment)
//   cpu_en    out  registered CPU clock enable
//   btn_db    out  debounced button level
//   state_o   out  FSM state register
//   step_cnt  out  count of cycles with cpu_en=1 (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEFAULT,
   parameter int SLOW_W  = SLOW_W_DEFAULT,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_mode,
   input  logic             auto,
   input  logic             btn,
   input  logic             halt,
   input  logic             clr_cnt,
   output logic             cpu_en,
   output logic             btn_db,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] step_cnt
);

   state_t            state_q, state_d, target;
   logic [SLOW_W-1:0] slow_q, slow_d;
   logic              cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              press;

   btn_debounce #(
      .DEB_CNT (DEB_CNT)
   ) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .btn_db (btn_db),
      .press  (press)
   );

   always_comb begin
      target   = step_mode ? (auto ? S_AUTO : S_STEP_IDLE) : S_RUN;
      state_d  = target;
      cpu_en_d = 1'b0;

      // A press only fires from a settled manual-idle state; anywhere else it
      // is dropped rather than remembered.
      if (state_q == S_STEP_IDLE && press && !halt && target == S_STEP_IDLE) begin
         state_d = S_STEP_FIRE;
      end

      // Restart the slow period on entry so the first auto pulse is a full
      // period after the mode is selected.
      if (state_d == S_AUTO && state_q != S_AUTO) begin
         slow_d = '0;
      end else begin
         slow_d = slow_q + SLOW_W'(1);
      end

      case (state_q)
         S_RUN:       cpu_en_d = ~halt;
         S_STEP_FIRE: cpu_en_d = 1'b1;
         S_AUTO:      cpu_en_d = (&slow_q) & ~halt;
         default:     cpu_en_d = 1'b0;
      endcase

      if (clr_cnt) begin
         cnt_d = '0;
      end else if (cpu_en_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_STEP_IDLE;
         slow_q   <= '0;
         cpu_en_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         slow_q   <= slow_d;
         cpu_en_q <= cpu_en_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cpu_en   = cpu_en_q;
   assign state_o  = state_q;
   assign step_cnt = cnt_q;

endmodule
